// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one instruction/data memory port between the fetch stage
//             and the load/store stage. Both requesters and the memory use a
//             two-phase toggle handshake (trigger toggles to request, ready
//             follows it to complete). Grants are round-robin, one memory
//             transaction is in flight at a time, the memory's ready toggle is
//             synchronised, and a watchdog forces completion of a memory
//             access that never answers.
//  Ports    : clk, rst                     - clock / synchronous active-high reset
//             fetchTriggerIn/AddrIn        - fetch request (read only)
//             fetchReadyOut/DataOut        - fetch completion toggle / word
//             lsuTriggerIn/AddrIn/WeIn/WdataIn - load/store request
//             lsuReadyOut/DataOut          - load/store completion / load data
//             memAddrOut/WeOut/WdataOut    - memory request payload
//             memTriggerOut, memReadyIn    - memory toggle handshake
//             memDataIn                    - memory read data
//             grantOut                     - 0 = fetch, 1 = lsu (current/last)
//             busyOut                      - transaction in progress
//             errorOut                     - sticky watchdog timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchTriggerIn,
    input  logic [ADDR_W-1:0] fetchAddrIn,
    output logic              fetchReadyOut,
    output logic [DATA_W-1:0] fetchDataOut,
    input  logic              lsuTriggerIn,
    input  logic [ADDR_W-1:0] lsuAddrIn,
    input  logic              lsuWeIn,
    input  logic [DATA_W-1:0] lsuWdataIn,
    output logic              lsuReadyOut,
    output logic [DATA_W-1:0] lsuDataOut,
    output logic [ADDR_W-1:0] memAddrOut,
    output logic              memWeOut,
    output logic [DATA_W-1:0] memWdataOut,
    output logic              memTriggerOut,
    input  logic              memReadyIn,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              grantOut,
    output logic              busyOut,
    output logic              errorOut
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] c_wd_max  = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [WD_W-1:0]        r_wd;
    logic                   r_last_grant;
    logic                   r_phase;

    logic                   w_mem_rdy;
    logic                   w_fetch_pend;
    logic                   w_lsu_pend;
    logic                   w_pick_lsu;
    logic                   w_mem_ok;
    logic                   w_wd_expired;
    logic [DATA_W-1:0]      w_cap_data;

    // memReadyIn is asynchronous to clk; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], memReadyIn};
        end
    end

    always_comb begin
        w_mem_rdy    = r_sync[SYNC_STAGES-1];
        w_fetch_pend = fetchTriggerIn != fetchReadyOut;
        w_lsu_pend   = lsuTriggerIn != lsuReadyOut;
        // lsu wins alone, or on a tie when fetch was served last.
        w_pick_lsu   = w_lsu_pend && (!w_fetch_pend || !r_last_grant);
        w_mem_ok     = w_mem_rdy == memTriggerOut;
        w_wd_expired = r_wd == c_wd_last;
        w_cap_data   = w_mem_ok ? memDataIn : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wd          <= '0;
            r_last_grant  <= 1'b0;
            r_phase       <= 1'b0;
            fetchReadyOut <= 1'b0;
            fetchDataOut  <= '0;
            lsuReadyOut   <= 1'b0;
            lsuDataOut    <= '0;
            memAddrOut    <= '0;
            memWeOut      <= 1'b0;
            memWdataOut   <= '0;
            memTriggerOut <= 1'b0;
            grantOut      <= 1'b0;
            busyOut       <= 1'b0;
            errorOut      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fetch_pend || w_lsu_pend) begin
                        busyOut <= 1'b1;
                        r_state <= S_ISSUE;
                        if (w_pick_lsu) begin
                            grantOut    <= 1'b1;
                            memAddrOut  <= lsuAddrIn;
                            memWeOut    <= lsuWeIn;
                            memWdataOut <= lsuWdataIn;
                            r_phase     <= lsuTriggerIn;
                        end else begin
                            // Fetch is read-only; drive a clean zero write word.
                            grantOut    <= 1'b0;
                            memAddrOut  <= fetchAddrIn;
                            memWeOut    <= 1'b0;
                            memWdataOut <= '0;
                            r_phase     <= fetchTriggerIn;
                        end
                    end
                end

                // Payload has been stable for a full cycle before this toggle.
                S_ISSUE: begin
                    memTriggerOut <= ~memTriggerOut;
                    r_wd          <= '0;
                    r_state       <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_mem_ok || w_wd_expired) begin
                        // Ready takes the phase latched at grant, so a toggle
                        // made during service stays pending.
                        if (grantOut) begin
                            lsuReadyOut <= r_phase;
                            if (!memWeOut) begin
                                lsuDataOut <= w_cap_data;
                            end
                        end else begin
                            fetchReadyOut <= r_phase;
                            fetchDataOut  <= w_cap_data;
                        end
                        if (!w_mem_ok) begin
                            errorOut <= 1'b1;
                            r_wd     <= c_wd_max;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_DONE: begin
                    r_last_grant <= grantOut;
                    busyOut      <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    busyOut <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//             model predicts grants, handshake toggles, data and latency;
//             directed tests pin literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetchTriggerIn = 1'b0;
    logic [AW-1:0] fetchAddrIn = '0;
    logic          fetchReadyOut;
    logic [DW-1:0] fetchDataOut;
    logic          lsuTriggerIn = 1'b0;
    logic [AW-1:0] lsuAddrIn = '0;
    logic          lsuWeIn = 1'b0;
    logic [DW-1:0] lsuWdataIn = '0;
    logic          lsuReadyOut;
    logic [DW-1:0] lsuDataOut;
    logic [AW-1:0] memAddrOut;
    logic          memWeOut;
    logic [DW-1:0] memWdataOut;
    logic          memTriggerOut;
    logic          memReadyIn = 1'b0;
    logic [DW-1:0] memDataIn = '0;
    logic          grantOut;
    logic          busyOut;
    logic          errorOut;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .fetchTriggerIn(fetchTriggerIn), .fetchAddrIn(fetchAddrIn),
        .fetchReadyOut(fetchReadyOut), .fetchDataOut(fetchDataOut),
        .lsuTriggerIn(lsuTriggerIn), .lsuAddrIn(lsuAddrIn), .lsuWeIn(lsuWeIn),
        .lsuWdataIn(lsuWdataIn), .lsuReadyOut(lsuReadyOut), .lsuDataOut(lsuDataOut),
        .memAddrOut(memAddrOut), .memWeOut(memWeOut), .memWdataOut(memWdataOut),
        .memTriggerOut(memTriggerOut), .memReadyIn(memReadyIn), .memDataIn(memDataIn),
        .grantOut(grantOut), .busyOut(busyOut), .errorOut(errorOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory environment (zero-delay responder) ----------------
    logic [DW-1:0] mem_arr [0:255];
    bit            mem_en = 1'b1;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            memReadyIn = 1'b0;
        end else if (mem_en && (memTriggerOut != memReadyIn)) begin
            if (memWeOut) mem_arr[memAddrOut[9:2]] = memWdataOut;
            memDataIn  = mem_arr[memAddrOut[9:2]];
            memReadyIn = memTriggerOut;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] m_mem [0:255];
    logic          m_fready, m_lready, m_busy, m_g, m_mtrig, m_err, m_last, m_phase, m_we, m_ok;
    logic [DW-1:0] m_fdata, m_ldata, m_wd;
    logic [AW-1:0] m_addr;
    int            m_cnt, m_lat;
    bit            grant_log [$];

    logic          p_rst = 1'b1;
    logic          p_ftrig, p_ltrig, p_lwe;
    logic [AW-1:0] p_faddr, p_laddr;
    logic [DW-1:0] p_lwd;

    always @(negedge clk) begin : p_cmp
        bit pf, pl;
        if (p_rst) begin
            m_fready = 0; m_lready = 0; m_busy = 0; m_g = 0; m_mtrig = 0; m_err = 0;
            m_last = 0; m_phase = 0; m_we = 0; m_fdata = '0; m_ldata = '0; m_wd = '0;
            m_addr = '0; m_cnt = 0; m_lat = 0; m_ok = 1;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 1) m_mtrig = ~m_mtrig;
            if (m_cnt == m_lat) begin
                if (m_g) begin
                    m_lready = m_phase;
                    if (!m_we) m_ldata = m_ok ? m_mem[m_addr[9:2]] : '0;
                    else if (m_ok) m_mem[m_addr[9:2]] = m_wd;
                end else begin
                    m_fready = m_phase;
                    m_fdata  = m_ok ? m_mem[m_addr[9:2]] : '0;
                end
                if (!m_ok) m_err = 1;
            end
            if (m_cnt == m_lat + 1) begin
                m_busy = 0;
                m_last = m_g;
            end
        end else begin
            pf = p_ftrig != m_fready;
            pl = p_ltrig != m_lready;
            if (pf || pl) begin
                m_g     = (pf && pl) ? ~m_last : pl;
                m_busy  = 1;
                m_cnt   = 0;
                m_ok    = mem_en;
                m_lat   = mem_en ? SYNC + 2 : TMO + 1;
                m_addr  = m_g ? p_laddr : p_faddr;
                m_we    = m_g ? p_lwe : 1'b0;
                m_wd    = m_g ? p_lwd : '0;
                m_phase = m_g ? p_ltrig : p_ftrig;
                grant_log.push_back(m_g);
            end
        end
        chk("fetchReadyOut", fetchReadyOut, m_fready);
        chk("lsuReadyOut",   lsuReadyOut,   m_lready);
        chk("fetchDataOut",  fetchDataOut,  m_fdata);
        chk("lsuDataOut",    lsuDataOut,    m_ldata);
        chk("busyOut",       busyOut,       m_busy);
        chk("grantOut",      grantOut,      m_g);
        chk("memTriggerOut", memTriggerOut, m_mtrig);
        chk("memAddrOut",    memAddrOut,    m_addr);
        chk("memWeOut",      memWeOut,      m_we);
        chk("memWdataOut",   memWdataOut,   m_wd);
        chk("errorOut",      errorOut,      m_err);
        p_rst = rst; p_ftrig = fetchTriggerIn; p_faddr = fetchAddrIn;
        p_ltrig = lsuTriggerIn; p_laddr = lsuAddrIn; p_lwe = lsuWeIn; p_lwd = lsuWdataIn;
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch_req(input logic [AW-1:0] a);
        @(posedge clk); #2;
        fetchAddrIn    = a;
        fetchTriggerIn = ~fetchTriggerIn;
    endtask

    task automatic lsu_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        @(posedge clk); #2;
        lsuAddrIn    = a;
        lsuWeIn      = we;
        lsuWdataIn   = wd;
        lsuTriggerIn = ~lsuTriggerIn;
    endtask

    task automatic wait_ready(input bit is_lsu, input string nm);
        int n = 0;
        while ((is_lsu ? (lsuReadyOut != lsuTriggerIn) : (fetchReadyOut != fetchTriggerIn)) && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk(nm, n < 40, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; fetchTriggerIn = 1'b0; lsuTriggerIn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic old_trig;
        int   n;
        for (int i = 0; i < 256; i++) begin mem_arr[i] = '0; m_mem[i] = '0; end
        mem_arr[8'h04] = 32'hE3A01005; m_mem[8'h04] = 32'hE3A01005; // 0x10
        mem_arr[8'h00] = 32'hE1A00000; m_mem[8'h00] = 32'hE1A00000; // 0x00
        mem_arr[8'h10] = 32'h12345678; m_mem[8'h10] = 32'h12345678; // 0x40

        do_reset();
        @(posedge clk); #1;
        chk("reset_busy", busyOut, 1'b0);
        chk("reset_memTrigger", memTriggerOut, 1'b0);
        chk("reset_error", errorOut, 1'b0);

        // Fetch only: exact latency
        fetch_req(32'h10);
        @(posedge clk); #1; chk("fetch_memTrig_E", memTriggerOut, 1'b0);
        @(posedge clk); #1; chk("fetch_memTrig_E1", memTriggerOut, 1'b1);
        repeat (2) @(posedge clk); #1; chk("fetch_ready_early", fetchReadyOut, 1'b0);
        @(posedge clk); #1;
        chk("fetch_ready_5", fetchReadyOut, 1'b1);
        chk("fetch_data", fetchDataOut, 32'hE3A01005);

        // Simultaneous requests from reset: lsu first
        do_reset();
        @(posedge clk); #2;
        fetchAddrIn = 32'h0; fetchTriggerIn = 1'b1;
        lsuAddrIn = 32'h40; lsuWeIn = 1'b0; lsuWdataIn = '0; lsuTriggerIn = 1'b1;
        wait_ready(1'b1, "sim_lsu_done");
        chk("sim_grant_lsu", grantOut, 1'b1);
        chk("sim_fetch_pending", fetchReadyOut, 1'b0);
        chk("sim_lsu_data", lsuDataOut, 32'h12345678);
        wait_ready(1'b0, "sim_fetch_done");
        chk("sim_grant_fetch", grantOut, 1'b0);
        chk("sim_fetch_data", fetchDataOut, 32'hE1A00000);

        // Back-to-back fairness
        grant_log.delete();
        fork
            begin
                for (int r = 0; r < 4; r++) begin
                    fetch_req(32'h10);
                    wait_ready(1'b0, "fair_fetch_done");
                end
            end
            begin
                for (int q = 0; q < 4; q++) begin
                    lsu_req(32'h40, 1'b0, '0);
                    wait_ready(1'b1, "fair_lsu_done");
                end
            end
        join
        chk("fair_count", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size() && k < 8; k++)
            chk($sformatf("fair_grant_%0d", k), grant_log[k], (k % 2 == 0) ? 1'b1 : 1'b0);

        // Store then load-back
        old_trig = memTriggerOut;
        lsu_req(32'h80, 1'b1, 32'hCAFEF00D);
        n = 0;
        while (memTriggerOut == old_trig && n < 20) begin @(posedge clk); #1; n++; end
        chk("store_trig_seen", n < 20, 1'b1);
        chk("store_we", memWeOut, 1'b1);
        chk("store_wdata", memWdataOut, 32'hCAFEF00D);
        wait_ready(1'b1, "store_done");
        chk("store_lsu_data_held", lsuDataOut, 32'h12345678);
        lsu_req(32'h80, 1'b0, '0);
        wait_ready(1'b1, "loadback_done");
        chk("loadback_data", lsuDataOut, 32'hCAFEF00D);

        // Watchdog timeout
        mem_en = 1'b0;
        fetch_req(32'h10);
        repeat (9) @(posedge clk); #1;
        chk("tmo_not_yet", fetchReadyOut != fetchTriggerIn, 1'b1);
        @(posedge clk); #1;
        chk("tmo_ready", fetchReadyOut, fetchTriggerIn);
        chk("tmo_error", errorOut, 1'b1);
        chk("tmo_data", fetchDataOut, 32'h0);
        repeat (5) @(posedge clk); #1;
        chk("tmo_error_sticky", errorOut, 1'b1);
        do_reset();
        mem_en = 1'b1;
        @(posedge clk); #1;
        chk("tmo_error_cleared", errorOut, 1'b0);

        // Reset while in WAIT
        fetch_req(32'h10);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1; fetchTriggerIn = 1'b0; lsuTriggerIn = 1'b0;
        @(posedge clk); #1;
        chk("rstw_busy", busyOut, 1'b0);
        chk("rstw_memTrig", memTriggerOut, 1'b0);
        chk("rstw_fready", fetchReadyOut, 1'b0);
        chk("rstw_fdata", fetchDataOut, 32'h0);
        chk("rstw_addr", memAddrOut, 32'h0);
        #1 rst = 1'b0;
        fetch_req(32'h10);
        wait_ready(1'b0, "rstw_fetch_done");
        chk("rstw_fetch_data", fetchDataOut, 32'hE3A01005);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
